clock_generator: RTL and testbench
==================================

# clock_generator

- Master-timing source for the four-phase W/X/Y/Z computer clock.
- Divides the oscillator clock into the three phase-control flip-flop pairs (CGPP/CGPPN, CGQP/CGQPN, CGRP/CGRPN) that the clock drivers gate into the W, X, Y and Z phases.
- Produces the BOP enable, which opens only on whole W-X-Y-Z cycles after a power-on settling delay.

## Interface
- DIV, 4: CLK cycles per phase; legal range 1..255.
- STARTUP_CYCLES, 16: number of complete W-X-Y-Z cycles after reset during which BOP is held low; legal range 0..65535.

- CLK  in  1  oscillator clock; all state changes on the rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- RUN  in  1  request that phase clocks be enabled; sampled only at cycle boundaries.
- STEP  in  1  single-cycle request; present only with CG_SINGLE_STEP_EN.
- CGPP, CGPPN  out  1  P phase flip-flop and its complement.
- CGQP, CGQPN  out  1  Q phase flip-flop and its complement.
- CGRP, CGRPN  out  1  R phase flip-flop and its complement.
- BOP  out  1  phase-clock enable to the clock drivers.
- PHASE  out  2  current phase: 0=W, 1=X, 2=Y, 3=Z.
- CYC_START  out  1  high for the first CLK of every W phase.
- HALTED  out  1  equals ~BOP.

## Operation
- **Phase sequencer.** Runs continuously out of reset, independent of RUN. Phase encoding (P,Q,R):
  - W = 1,0,1
  - X = 0,1,1
  - Y = 1,1,0
  - Z = 0,0,0
- **Phase transitions.** P toggles at every phase boundary. Q and R each toggle every second boundary, so exactly two of P/Q/R change per boundary. The order is W→X→Y→Z→W.
- **Registered outputs.** All CG outputs are registered. Each N output is the exact complement of its P output at all times, including during reset.
- **Prescaler.** cnt runs 0..DIV-1. When cnt==DIV-1, the next edge advances PHASE and clears cnt. With DIV=1 the phase advances every edge.
- **Startup counter.** Counts CYC_START pulses and saturates at STARTUP_CYCLES. "Started" means the count has reached STARTUP_CYCLES.
- **BOP update.** BOP changes only on the edge that enters W, where BOP <= RUN & started (see Configuration for the step term).
  - Consequence: BOP is never asserted or removed mid-cycle, so the drivers always see whole W..Z cycles.
  - A RUN change mid-cycle takes effect at the next W entry.
  - RUN toggling within a single cycle has no effect other than its value at the boundary.
- **Started condition.** Evaluated using the count before the current W entry. The earliest W phase with BOP=1 is W entry number STARTUP_CYCLES+1 after reset. With STARTUP_CYCLES=0 it is the first W entry.
- **Reset values (asynchronous, immediate, including mid-phase).**
  - PHASE=3 (Z), cnt=0.
  - CGPP=0, CGQP=0, CGRP=0; CGPPN=1, CGQPN=1, CGRPN=1.
  - BOP=0, HALTED=1, CYC_START=0.
  - Startup count=0; step latch clear.
  - Truncation of an in-progress cycle by reset is accepted.

## Timing
- **First W entry.** Occurs on the DIV-th rising edge after RST_N deasserts. The first sampled edge counts as edge 1.
- **Cycle length.** Phase length is DIV CLK; cycle length is 4·DIV CLK.
- **Coincident outputs.** CYC_START, the change of PHASE to 0, the P/Q/R change to W, and any BOP change all appear on the same edge, so they have zero relative latency.
- **RUN latency.**
  - Deassertion: BOP falls between 1 and 4·DIV CLK later, at the next W entry.
  - Assertion after started: BOP rises within the same bound.

## Configuration
- **CG_SINGLE_STEP_EN defined:**
  - STEP exists. A STEP high on any edge while BOP=0 and started sets the step latch.
  - At the next W entry: BOP <= (RUN & started) | step_latch, and the step latch clears.
  - If RUN=0, BOP is therefore high for exactly one cycle (4·DIV CLK).
  - STEP while BOP=1 or before started is ignored.
  - Multiple STEP pulses within one cycle produce one step.
- **Not defined:**
  - No STEP port, no step latch. BOP depends only on RUN and started.

## Test plan
- **Reset/sequence.** DIV=4, STARTUP_CYCLES=2, RUN=1; release RST_N.
  - Outputs hold the reset values.
  - First CYC_START on edge 4.
  - P/Q/R follow 101,011,110,000 with 4 CLK per phase.
  - BOP=0 through W entries 1–2 and rises at W entry 3 (edge 36).
- **Complements.** For DIV ∈ {1,3} over 100 cycles: each CGxxN==~CGxxP on every edge, and exactly two of P/Q/R change per phase boundary.
- **RUN drop mid-cycle.** Drop RUN during phase X.
  - BOP stays 1 through Y and Z, falls at the next CYC_START, HALTED=1.
  - Reasserting RUN in Y restores BOP at the following W entry.
- **Async reset.** Assert RST_N=0 during phase Y with BOP=1: BOP=0, PHASE=3 and CG outputs go to reset values before the next CLK edge. After release, the startup delay restarts in full.
- **Single step (CG_SINGLE_STEP_EN, RUN=0, started).** Pulse STEP for 2 CLK in phase X: BOP=1 for exactly 16 CLK from the next W entry (DIV=4), then 0. A STEP during that BOP=1 window is ignored.
- **STARTUP_CYCLES=0, DIV=1.** BOP=1 at the first CYC_START (edge 1), and CYC_START recurs every 4 CLK.

Source files
------------

// File: rtl/clock_generator.sv
// Four-phase W/X/Y/Z master timing source with startup-gated, cycle-aligned BOP enable.
// Defining CG_SINGLE_STEP_EN adds the STEP port and a one-cycle step latch.
module clock_generator #(
  parameter int unsigned DIV            = 4,
  parameter int unsigned STARTUP_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RUN,
`ifdef CG_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic       CGPP,
  output logic       CGPPN,
  output logic       CGQP,
  output logic       CGQPN,
  output logic       CGRP,
  output logic       CGRPN,
  output logic       BOP,
  output logic [1:0] PHASE,
  output logic       CYC_START,
  output logic       HALTED
);

  typedef enum logic [1:0] {
    PH_W = 2'd0,
    PH_X = 2'd1,
    PH_Y = 2'd2,
    PH_Z = 2'd3
  } phase_t;

  localparam logic [7:0]  CNT_MAX   = 8'(DIV - 1);
  localparam logic [15:0] START_MAX = 16'(STARTUP_CYCLES);

  phase_t      phase;
  phase_t      phase_nxt;
  logic [2:0]  pqr_nxt;
  logic [7:0]  cnt;
  logic [15:0] starts;
  logic        wrap;
  logic        w_entry;
  logic        started;
  logic        bop_nxt;

  assign wrap    = (cnt == CNT_MAX);
  assign w_entry = wrap && (phase == PH_Z);
  assign started = (starts == START_MAX);
  assign PHASE   = phase;

  always_comb begin
    phase_nxt = PH_W;
    case (phase)
      PH_W:    phase_nxt = PH_X;
      PH_X:    phase_nxt = PH_Y;
      PH_Y:    phase_nxt = PH_Z;
      default: phase_nxt = PH_W;
    endcase
  end

  // P toggles every boundary; Q and R alternate, so two bits change per step.
  always_comb begin
    pqr_nxt = 3'b000;
    case (phase_nxt)
      PH_W:    pqr_nxt = 3'b101;
      PH_X:    pqr_nxt = 3'b011;
      PH_Y:    pqr_nxt = 3'b110;
      default: pqr_nxt = 3'b000;
    endcase
  end

`ifdef CG_SINGLE_STEP_EN
  logic step_latch;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      step_latch <= 1'b0;
    else if (w_entry)
      step_latch <= 1'b0;
    else if (STEP && !BOP && started)
      step_latch <= 1'b1;
  end

  assign bop_nxt = (RUN && started) || step_latch;
`else
  assign bop_nxt = RUN && started;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase     <= PH_Z;
      cnt       <= '0;
      starts    <= '0;
      CGPP      <= 1'b0;
      CGQP      <= 1'b0;
      CGRP      <= 1'b0;
      CGPPN     <= 1'b1;
      CGQPN     <= 1'b1;
      CGRPN     <= 1'b1;
      BOP       <= 1'b0;
      HALTED    <= 1'b1;
      CYC_START <= 1'b0;
    end else begin
      CYC_START <= w_entry;
      if (wrap) begin
        cnt                  <= '0;
        phase                <= phase_nxt;
        {CGPP, CGQP, CGRP}    <= pqr_nxt;
        {CGPPN, CGQPN, CGRPN} <= ~pqr_nxt;
      end else begin
        cnt <= cnt + 8'd1;
      end
      // BOP only moves on W entry; started uses the count before this entry.
      if (w_entry) begin
        BOP    <= bop_nxt;
        HALTED <= ~bop_nxt;
        if (!started)
          starts <= starts + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_generator.sv
// Self-checking bench for clock_generator: three parameterisations against an edge-count model.
module tb_clock_generator;

  localparam int unsigned DA = 4;
  localparam int unsigned SA = 2;
  localparam int unsigned DB = 3;
  localparam int unsigned SB = 1;
  localparam int unsigned DC = 1;
  localparam int unsigned SC = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, run_a, run_b, run_c, step_a;
  logic a_pp, a_ppn, a_qp, a_qpn, a_rp, a_rpn, a_bop, a_cyc, a_halt;
  logic b_pp, b_ppn, b_qp, b_qpn, b_rp, b_rpn, b_bop, b_cyc, b_halt;
  logic c_pp, c_ppn, c_qp, c_qpn, c_rp, c_rpn, c_bop, c_cyc, c_halt;
  logic [1:0] a_ph, b_ph, c_ph;
  logic [10:0] act_a;

  int unsigned passed = 0;
  int unsigned total  = 0;

  clock_generator #(.DIV(DA), .STARTUP_CYCLES(SA)) u_a (
    .CLK(clk), .RST_N(rst_a), .RUN(run_a),
`ifdef CG_SINGLE_STEP_EN
    .STEP(step_a),
`endif
    .CGPP(a_pp), .CGPPN(a_ppn), .CGQP(a_qp), .CGQPN(a_qpn), .CGRP(a_rp), .CGRPN(a_rpn),
    .BOP(a_bop), .PHASE(a_ph), .CYC_START(a_cyc), .HALTED(a_halt)
  );

  clock_generator #(.DIV(DB), .STARTUP_CYCLES(SB)) u_b (
    .CLK(clk), .RST_N(rst_b), .RUN(run_b),
`ifdef CG_SINGLE_STEP_EN
    .STEP(1'b0),
`endif
    .CGPP(b_pp), .CGPPN(b_ppn), .CGQP(b_qp), .CGQPN(b_qpn), .CGRP(b_rp), .CGRPN(b_rpn),
    .BOP(b_bop), .PHASE(b_ph), .CYC_START(b_cyc), .HALTED(b_halt)
  );

  clock_generator #(.DIV(DC), .STARTUP_CYCLES(SC)) u_c (
    .CLK(clk), .RST_N(rst_c), .RUN(run_c),
`ifdef CG_SINGLE_STEP_EN
    .STEP(1'b0),
`endif
    .CGPP(c_pp), .CGPPN(c_ppn), .CGQP(c_qp), .CGQPN(c_qpn), .CGRP(c_rp), .CGRPN(c_rpn),
    .BOP(c_bop), .PHASE(c_ph), .CYC_START(c_cyc), .HALTED(c_halt)
  );

  assign act_a = {a_ph, a_pp, a_qp, a_rp, a_ppn, a_qpn, a_rpn, a_cyc, a_bop, a_halt};

  // Reference for instance A: everything derives from edges since reset release.
  int unsigned mt;
  logic m_bop, m_step;

  function automatic int unsigned entries(input int unsigned t);
    return (t < DA) ? 0 : (t - DA) / (4 * DA) + 1;
  endfunction

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      mt     <= 0;
      m_bop  <= 1'b0;
      m_step <= 1'b0;
    end else begin
      mt <= mt + 1;
      if (mt + 1 >= DA && (mt + 1 - DA) % (4 * DA) == 0) begin
        m_bop  <= (run_a && entries(mt) >= SA) || m_step;
        m_step <= 1'b0;
      end else if (step_a && !m_bop && entries(mt) >= SA) begin
        m_step <= 1'b1;
      end
    end
  end

  function automatic logic [10:0] exp_a();
    logic [1:0] ph;
    logic [2:0] pqr;
    logic       cyc;
    ph  = (mt < DA) ? 2'd3 : 2'(((mt - DA) / DA) % 4);
    cyc = (mt >= DA) && ((mt - DA) % (4 * DA) == 0);
    case (ph)
      2'd0:    pqr = 3'b101;
      2'd1:    pqr = 3'b011;
      2'd2:    pqr = 3'b110;
      default: pqr = 3'b000;
    endcase
    return {ph, pqr, ~pqr, cyc, m_bop, ~m_bop};
  endfunction

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    run_a = 1'b0; run_b = 1'b1; run_c = 1'b1; step_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (act_a !== 11'b11_000_111_0_0_1) $display("FAIL reset_a got %b want %b", act_a, 11'b11_000_111_0_0_1);
      else passed++;
      total++;
      if ({b_ph, b_pp, b_ppn, b_bop, b_halt, c_ph, c_rp, c_rpn, c_cyc} !== 12'b11_01_01_11_01_0)
        $display("FAIL reset_bc got %b want %b",
                 {b_ph, b_pp, b_ppn, b_bop, b_halt, c_ph, c_rp, c_rpn, c_cyc}, 12'b11_01_01_11_01_0);
      else passed++;
    end
    run_a = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
  endtask

  task automatic test_sequence();
    int unsigned first_cyc = 0;
    int unsigned first_bop = 0;
    for (int unsigned i = 1; i <= 48; i++) begin
      @(negedge clk);
      total++;
      if (act_a !== exp_a()) $display("FAIL seq edge=%0d got %b want %b", i, act_a, exp_a());
      else passed++;
      if (a_cyc === 1'b1 && first_cyc == 0) first_cyc = i;
      if (a_bop === 1'b1 && first_bop == 0) first_bop = i;
    end
    total++;
    if (first_cyc != 4) $display("FAIL first_cyc_edge got %0d want 4", first_cyc);
    else passed++;
    total++;
    if (first_bop != 36) $display("FAIL first_bop_edge got %0d want 36", first_bop);
    else passed++;
  endtask

  task automatic test_run_drop();
    int unsigned budget = 0;
    logic seen = 1'b0;
    do begin @(negedge clk); budget++; end while (!(a_ph == 2'd1 && a_bop === 1'b1) && budget < 64);
    total++;
    if (!(a_ph == 2'd1 && a_bop === 1'b1)) $display("FAIL run_drop_wait got ph=%0d bop=%b want ph=1 bop=1", a_ph, a_bop);
    else passed++;
    run_a = 1'b0;
    for (int unsigned i = 0; i < 64; i++) begin
      @(negedge clk);
      total++;
      if (act_a !== exp_a()) $display("FAIL run_drop i=%0d got %b want %b", i, act_a, exp_a());
      else passed++;
      if (!seen && a_cyc === 1'b1) begin
        seen = 1'b1;
        total++;
        if ({a_bop, a_halt} !== 2'b01) $display("FAIL run_drop_fall got %b want 01", {a_bop, a_halt});
        else passed++;
      end else if (!seen) begin
        total++;
        if (a_bop !== 1'b1) $display("FAIL run_drop_hold got %b want 1", a_bop);
        else passed++;
      end
      if (seen && a_ph == 2'd2 && !run_a) run_a = 1'b1;
    end
    total++;
    if (a_bop !== 1'b1) $display("FAIL run_restore got %b want 1", a_bop);
    else passed++;
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      total++;
      if (act_a !== exp_a()) $display("FAIL random i=%0d got %b want %b", i, act_a, exp_a());
      else passed++;
      if ($urandom_range(7) == 0) run_a = ~run_a;
    end
    run_a = 1'b1;
  endtask

  task automatic test_async_reset();
    int unsigned budget = 0;
    int unsigned first_bop = 0;
    do begin @(negedge clk); budget++; end while (!(a_ph == 2'd2 && a_bop === 1'b1) && budget < 200);
    total++;
    if (!(a_ph == 2'd2 && a_bop === 1'b1)) $display("FAIL async_wait got ph=%0d bop=%b want ph=2 bop=1", a_ph, a_bop);
    else passed++;
    #2 rst_a = 1'b0;
    #1;
    total++;
    if (act_a !== 11'b11_000_111_0_0_1) $display("FAIL async_reset got %b want %b", act_a, 11'b11_000_111_0_0_1);
    else passed++;
    @(negedge clk);
    rst_a = 1'b1;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      total++;
      if (act_a !== exp_a()) $display("FAIL async_restart edge=%0d got %b want %b", i, act_a, exp_a());
      else passed++;
      if (a_bop === 1'b1 && first_bop == 0) first_bop = i;
    end
    total++;
    if (first_bop != 36) $display("FAIL async_first_bop got %0d want 36", first_bop);
    else passed++;
  endtask

`ifdef CG_SINGLE_STEP_EN
  task automatic test_step();
    int unsigned budget = 0;
    int unsigned hi = 0;
    run_a = 1'b0;
    do begin @(negedge clk); budget++; end while (!(a_ph == 2'd1 && a_bop === 1'b0) && budget < 100);
    total++;
    if (!(a_ph == 2'd1 && a_bop === 1'b0)) $display("FAIL step_wait got ph=%0d bop=%b want ph=1 bop=0", a_ph, a_bop);
    else passed++;
    step_a = 1'b1;
    for (int unsigned i = 0; i < 96; i++) begin
      if (i == 2) step_a = 1'b0;
      @(negedge clk);
      total++;
      if (act_a !== exp_a()) $display("FAIL step i=%0d got %b want %b", i, act_a, exp_a());
      else passed++;
      if (a_bop === 1'b1) hi++;
      step_a = (a_bop === 1'b1 && hi == 5);
    end
    step_a = 1'b0;
    total++;
    if (hi != 16) $display("FAIL step_width got %0d want 16", hi);
    else passed++;
  endtask
`endif

  task automatic test_complements();
    logic [2:0] pb, pc, nb, nc;
    logic [1:0] phb, phc;
    pb = {b_pp, b_qp, b_rp}; pc = {c_pp, c_qp, c_rp};
    phb = b_ph; phc = c_ph;
    for (int unsigned i = 0; i < 1200; i++) begin
      @(negedge clk);
      nb = {b_pp, b_qp, b_rp};
      nc = {c_pp, c_qp, c_rp};
      total++;
      if ({b_ppn, b_qpn, b_rpn, c_ppn, c_qpn, c_rpn} !== ~{nb, nc})
        $display("FAIL complement got %b want %b", {b_ppn, b_qpn, b_rpn, c_ppn, c_qpn, c_rpn}, ~{nb, nc});
      else passed++;
      if (nb != pb) begin
        total++;
        if ($countones(nb ^ pb) != 2 || b_ph != phb + 2'd1)
          $display("FAIL boundary_b got pqr %b->%b ph %0d->%0d want two bits and ph+1", pb, nb, phb, b_ph);
        else passed++;
      end
      if (nc != pc) begin
        total++;
        if ($countones(nc ^ pc) != 2 || c_ph != phc + 2'd1)
          $display("FAIL boundary_c got pqr %b->%b ph %0d->%0d want two bits and ph+1", pc, nc, phc, c_ph);
        else passed++;
      end
      pb = nb; pc = nc; phb = b_ph; phc = c_ph;
    end
  endtask

  task automatic test_startup0();
    rst_c = 1'b0;
    @(negedge clk);
    total++;
    if ({c_bop, c_cyc, c_ph} !== 4'b0011) $display("FAIL startup0_reset got %b want 0011", {c_bop, c_cyc, c_ph});
    else passed++;
    rst_c = 1'b1;
    for (int unsigned t = 1; t <= 40; t++) begin
      @(negedge clk);
      total++;
      if ({c_cyc, c_bop, c_ph} !== {(t % 4 == 1), 1'b1, 2'((t - 1) % 4)})
        $display("FAIL startup0 edge=%0d got %b want %b", t, {c_cyc, c_bop, c_ph},
                 {(t % 4 == 1), 1'b1, 2'((t - 1) % 4)});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_run_drop();
    test_random();
    test_async_reset();
`ifdef CG_SINGLE_STEP_EN
    test_step();
`endif
    test_complements();
    test_startup0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
